corner_finder: RTL

CORNER_FINDER -- requirements
Module: corner_finder

---
 rtl/corner_finder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/corner_finder.sv
`default_nettype none
// corner_finder: tracks the TL/TR/BR/BL extreme marker pixels of each frame and
// publishes them when the frame holds at least MIN_HITS hits.  Rev 1.0
module corner_finder #(
   parameter int MIN_HITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        frame_end,
   input  logic        pixel_valid,
   input  logic        pixel_hit,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [79:0] corners,
   output logic        corners_valid,
   output logic        frame_miss,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   localparam logic [15:0] c_MIN_HITS = 16'(MIN_HITS);
   localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

   state_t      state_q, state_d;
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [19:0] tl_q, tl_d;
   logic [19:0] tr_q, tr_d;
   logic [19:0] br_q, br_d;
   logic [19:0] bl_q, bl_d;
   logic [79:0] corners_q, corners_d;
   logic        corners_valid_q, corners_valid_d;
   logic        frame_miss_q, frame_miss_d;

   // Each accumulator stores the winning pixel {x,y}; its metric is recomputed.
   function automatic logic [10:0] sum_of(input logic [19:0] p);
      return {1'b0, p[19:10]} + {1'b0, p[9:0]};
   endfunction

   function automatic logic signed [10:0] diff_of(input logic [19:0] p);
      return $signed({1'b0, p[19:10]}) - $signed({1'b0, p[9:0]});
   endfunction

   logic [19:0]        w_pix;
   logic [10:0]        w_sum;
   logic signed [10:0] w_diff;
   logic               w_hit;
   logic               w_first;

   assign w_pix   = {x, y};
   assign w_sum   = sum_of(w_pix);
   assign w_diff  = diff_of(w_pix);
   assign w_hit   = pixel_valid & pixel_hit;
   assign w_first = (hit_cnt_q == 16'd0);

   always_comb begin
      state_d         = state_q;
      hit_cnt_d       = hit_cnt_q;
      tl_d            = tl_q;
      tr_d            = tr_q;
      br_d            = br_q;
      bl_d            = bl_q;
      corners_d       = corners_q;
      corners_valid_d = 1'b0;
      frame_miss_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               hit_cnt_d = 16'd0;
               state_d   = SCAN;
            end
         end

         SCAN: begin
            if (w_hit) begin
               if (hit_cnt_q != c_CNT_MAX) begin
                  hit_cnt_d = hit_cnt_q + 16'd1;
               end
               // Strict comparisons keep the earliest pixel on ties.
               if (w_first || (w_sum < sum_of(tl_q)))   tl_d = w_pix;
               if (w_first || (w_sum > sum_of(br_q)))   br_d = w_pix;
               if (w_first || (w_diff > diff_of(tr_q))) tr_d = w_pix;
               if (w_first || (w_diff < diff_of(bl_q))) bl_d = w_pix;
            end
            if (frame_end) begin
               state_d = PUBLISH;
            end else if (frame_start) begin
               hit_cnt_d = 16'd0;
            end
         end

         PUBLISH: begin
            if (hit_cnt_q >= c_MIN_HITS) begin
               corners_d       = {tl_q, tr_q, br_q, bl_q};
               corners_valid_d = 1'b1;
            end else begin
               frame_miss_d = 1'b1;
            end
            if (frame_start) begin
               hit_cnt_d = 16'd0;
               state_d   = SCAN;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         hit_cnt_q       <= 16'd0;
         tl_q            <= 20'd0;
         tr_q            <= 20'd0;
         br_q            <= 20'd0;
         bl_q            <= 20'd0;
         corners_q       <= 80'd0;
         corners_valid_q <= 1'b0;
         frame_miss_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         hit_cnt_q       <= hit_cnt_d;
         tl_q            <= tl_d;
         tr_q            <= tr_d;
         br_q            <= br_d;
         bl_q            <= bl_d;
         corners_q       <= corners_d;
         corners_valid_q <= corners_valid_d;
         frame_miss_q    <= frame_miss_d;
      end
   end

   assign corners       = corners_q;
   assign corners_valid = corners_valid_q;
   assign frame_miss    = frame_miss_q;
   assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire
